// File: rtl/trig_pkg.sv
// Shared definitions for the UART transmit arbiter.
//   state_t     : arbiter FSM state encoding
//   HDR_BASE    : base value of the per-packet source header byte
//   TIMEOUT_DEF : default mid-packet idle limit, in cycles
package trig_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_SEND = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    localparam logic [7:0] HDR_BASE    = 8'hA0;
    localparam int         TIMEOUT_DEF = 1000;

endpackage

// File: rtl/rr_pick.sv
// Round-robin selector.
//   req  : request vector
//   ptr  : index of the last grantee; the search starts at ptr+1
//   pick : one-hot winner, zero when no request is pending
module rr_pick #(
    parameter int NREQ = 3,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] pick
);

    always_comb begin
        int  j;
        logic found;
        pick  = '0;
        found = 1'b0;
        j     = 0;
        // Offset 1..NREQ so the last grantee is considered last.
        for (int i = 1; i <= NREQ; i++) begin
            j = (int'(ptr) + i) % NREQ;
            if (!found && req[j]) begin
                pick[j] = 1'b1;
                found   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tx_arbiter.sv
// Packet-atomic round-robin arbiter feeding a single byte-wide UART.
//   clk, reset  : clock and synchronous active-high reset
//   req         : per-requester packet request, held until the last byte is taken
//   in_valid    : per-requester byte valid
//   in_data     : per-requester byte
//   in_last     : per-requester last-byte marker
//   in_ready    : byte accepted (only ever for the granted index)
//   grant       : one-hot current owner, or zero
//   txBusy      : UART transmitter busy
//   txStart     : one-cycle start pulse to the UART
//   txData      : byte to the UART, valid while txStart is high
//   timeout_err : one-cycle pulse on a packet abort
//   busy        : high whenever the FSM is not idle
module tx_arbiter
    import trig_pkg::*;
#(
    parameter int NREQ      = 3,
    parameter bit HEADER_EN = 1'b1,
    parameter int TIMEOUT   = TIMEOUT_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      in_valid,
    input  logic [NREQ-1:0][7:0] in_data,
    input  logic [NREQ-1:0]      in_last,
    output logic [NREQ-1:0]      in_ready,
    output logic [NREQ-1:0]      grant,
    input  logic                 txBusy,
    output logic                 txStart,
    output logic [7:0]           txData,
    output logic                 timeout_err,
    output logic                 busy
);

    localparam int         IW      = $clog2(NREQ);
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    state_t            state, state_n;
    logic [NREQ-1:0]   grant_q, grant_n;
    logic [IW-1:0]     idx_q, idx_n;
    logic [IW-1:0]     ptr_q, ptr_n;
    logic              start_q, start_n;
    logic [7:0]        data_q, data_n;
    logic              last_q, last_n;
    logic              hdr_q, hdr_n;
    logic [15:0]       cnt_q, cnt_n;
    logic              err_q, err_n;

    logic [NREQ-1:0]   pick;
    logic [IW-1:0]     pick_idx;
    logic              accept, dropped, abort, release_own;

    rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req  (req),
        .ptr  (ptr_q),
        .pick (pick)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NREQ; i++)
            if (pick[i]) pick_idx = IW'(i);
    end

    assign accept = (state == ST_SEND) && req[idx_q] && in_valid[idx_q] && !txBusy;
    // Once the last byte has been taken the requester may drop req while we sit
    // in GAP; that is a normal end of packet, not an abort.
    assign dropped = (state != ST_IDLE) && !req[idx_q] &&
                     !(state == ST_GAP && last_q && !hdr_q);

    always_comb begin
        state_n     = state;
        grant_n     = grant_q;
        idx_n       = idx_q;
        ptr_n       = ptr_q;
        start_n     = 1'b0;
        data_n      = data_q;
        last_n      = last_q;
        hdr_n       = hdr_q;
        cnt_n       = cnt_q;
        err_n       = 1'b0;
        in_ready    = '0;
        abort       = 1'b0;
        release_own = 1'b0;

        case (state)
            ST_IDLE: begin
                cnt_n = '0;
                if (|req) begin
                    grant_n = pick;
                    idx_n   = pick_idx;
                    hdr_n   = 1'b0;
                    last_n  = 1'b0;
                    state_n = HEADER_EN ? ST_HDR : ST_SEND;
                end
            end
            ST_HDR: begin
                if (!txBusy) begin
                    start_n = 1'b1;
                    data_n  = HDR_BASE | 8'(idx_q);
                    hdr_n   = 1'b1;
                    state_n = ST_GAP;
                end
            end
            ST_SEND: begin
                if (accept) begin
                    in_ready[idx_q] = 1'b1;
                    start_n = 1'b1;
                    data_n  = in_data[idx_q];
                    last_n  = in_last[idx_q];
                    hdr_n   = 1'b0;
                    cnt_n   = '0;
                    state_n = ST_GAP;
                end else if (cnt_q == TO_LAST) begin
                    abort = 1'b1;
                end else begin
                    cnt_n = cnt_q + 16'd1;
                end
            end
            ST_GAP: begin
                // One dead cycle covers the UART's busy-rise latency.
                if (hdr_q || !last_q) state_n = ST_SEND;
                else                  release_own = 1'b1;
            end
            default: state_n = ST_IDLE;
        endcase

        if (dropped) abort = 1'b1;

        if (abort) begin
            start_n = 1'b0;
            data_n  = data_q;
            err_n   = 1'b1;
        end
        if (abort || release_own) begin
            state_n = ST_IDLE;
            grant_n = '0;
            ptr_n   = idx_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            grant_q <= '0;
            idx_q   <= '0;
            ptr_q   <= IW'(NREQ - 1);
            start_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
            hdr_q   <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_n;
            grant_q <= grant_n;
            idx_q   <= idx_n;
            ptr_q   <= ptr_n;
            start_q <= start_n;
            data_q  <= data_n;
            last_q  <= last_n;
            hdr_q   <= hdr_n;
            cnt_q   <= cnt_n;
            err_q   <= err_n;
        end
    end

    assign grant       = grant_q;
    assign txStart     = start_q;
    assign txData      = data_q;
    assign timeout_err = err_q;
    assign busy        = (state != ST_IDLE);

endmodule

// File: tb/tb_tx_arbiter.sv
// Directed bench for tx_arbiter. Three instances share the stimulus:
//   0: HEADER_EN=1, TIMEOUT=1000   1: HEADER_EN=1, TIMEOUT=8   2: HEADER_EN=0
// 'sel' picks the instance whose UART stream feeds the byte scoreboard.
module tb_tx_arbiter;

    logic            clk = 1'b0;
    logic            reset;
    logic [2:0]      req, in_valid, in_last;
    logic [2:0][7:0] in_data;
    logic            txBusy;

    logic [2:0] rdy_w   [3];
    logic [2:0] grant_w [3];
    logic       start_w [3];
    logic [7:0] data_w  [3];
    logic       err_w   [3];
    logic       busy_w  [3];

    always #5 clk = ~clk;

    tx_arbiter #(.NREQ(3), .HEADER_EN(1'b1), .TIMEOUT(1000)) dut_a (
        .clk(clk), .reset(reset), .req(req), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(rdy_w[0]), .grant(grant_w[0]), .txBusy(txBusy),
        .txStart(start_w[0]), .txData(data_w[0]), .timeout_err(err_w[0]), .busy(busy_w[0]));

    tx_arbiter #(.NREQ(3), .HEADER_EN(1'b1), .TIMEOUT(8)) dut_t (
        .clk(clk), .reset(reset), .req(req), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(rdy_w[1]), .grant(grant_w[1]), .txBusy(txBusy),
        .txStart(start_w[1]), .txData(data_w[1]), .timeout_err(err_w[1]), .busy(busy_w[1]));

    tx_arbiter #(.NREQ(3), .HEADER_EN(1'b0), .TIMEOUT(1000)) dut_n (
        .clk(clk), .reset(reset), .req(req), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(rdy_w[2]), .grant(grant_w[2]), .txBusy(txBusy),
        .txStart(start_w[2]), .txData(data_w[2]), .timeout_err(err_w[2]), .busy(busy_w[2]));

    int         n_chk = 0;
    int         n_err = 0;
    int         sel   = 0;
    int         cycn  = 0;
    logic [7:0] sb_q [$];
    int         starts [$];
    logic [2:0] rdy;
    logic       prev_start;
    logic       err_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: sample combinational in_ready before the edge, registered
    // outputs at the following negedge; UART bytes go through the scoreboard.
    task automatic cyc();
        #1;
        rdy = rdy_w[sel];
        if (rdy != 3'b000)
            chk("rdy_owner", 32'(((rdy & ~grant_w[sel]) == 3'b000) && $onehot(rdy)), 32'd1);
        @(posedge clk);
        @(negedge clk);
        cycn++;
        if (start_w[sel]) begin
            chk("start_spacing", 32'(prev_start), 32'd0);
            starts.push_back(cycn);
            if (sb_q.size() == 0) chk("sb_underflow", 32'(data_w[sel]), 32'hFFFF_FFFF);
            else                  chk("sb_byte", 32'(data_w[sel]), 32'(sb_q.pop_front()));
        end
        prev_start = start_w[sel];
        if (err_w[sel]) err_seen = 1'b1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        req      = '0;
        in_valid = '0;
        in_last  = '0;
        in_data  = '0;
        txBusy   = 1'b0;
        cyc();
        cyc();
        reset = 1'b0;
        sb_q.delete();
        starts.delete();
        prev_start = 1'b0;
        err_seen   = 1'b0;
    endtask

    task automatic wait_grant(input logic [2:0] exp);
        for (int i = 0; i < 40; i++) begin
            if (grant_w[sel] == exp) break;
            cyc();
        end
        chk("grant", 32'(grant_w[sel]), 32'(exp));
    endtask

    task automatic wait_starts(input int n);
        for (int i = 0; i < 40; i++) begin
            if (starts.size() >= n) break;
            cyc();
        end
        chk("start_seen", 32'(starts.size() >= n), 32'd1);
    endtask

    task automatic send_byte(input int g, input logic [7:0] d, input logic last, input logic drop);
        logic ok;
        ok          = 1'b0;
        in_valid[g] = 1'b1;
        in_data[g]  = d;
        in_last[g]  = last;
        for (int i = 0; i < 60; i++) begin
            cyc();
            if (rdy[g]) begin
                ok = 1'b1;
                break;
            end
        end
        chk("accept", 32'(ok), 32'd1);
        in_valid[g] = 1'b0;
        in_last[g]  = 1'b0;
        if (last && drop) req[g] = 1'b0;
    endtask

    initial begin
        logic [1:0] order [4];
        order = '{2'd0, 2'd1, 2'd2, 2'd0};
        @(negedge clk);

        // Reset state on every instance.
        do_reset();
        for (int s = 0; s < 3; s++) begin
            chk("rst_grant", 32'(grant_w[s]), 32'd0);
            chk("rst_start", 32'(start_w[s]), 32'd0);
            chk("rst_data",  32'(data_w[s]),  32'd0);
            chk("rst_err",   32'(err_w[s]),   32'd0);
            chk("rst_busy",  32'(busy_w[s]),  32'd0);
        end

        // Two-byte packet from requester 1 with header.
        sel = 0;
        sb_q.push_back(8'hA1); sb_q.push_back(8'h11); sb_q.push_back(8'h22);
        req[1] = 1'b1;
        wait_grant(3'b010);
        send_byte(1, 8'h11, 1'b0, 1'b0);
        send_byte(1, 8'h22, 1'b1, 1'b1);
        cyc();
        chk("pkt1_grant_clr", 32'(grant_w[0]), 32'd0);
        chk("pkt1_busy_clr",  32'(busy_w[0]),  32'd0);
        chk("pkt1_nstarts",   32'(starts.size()), 32'd3);
        if (starts.size() == 3) begin
            chk("pkt1_gap0", 32'(starts[1] - starts[0]), 32'd2);
            chk("pkt1_gap1", 32'(starts[2] - starts[1]), 32'd2);
        end
        chk("pkt1_no_err", 32'(err_seen), 32'd0);
        chk("pkt1_sb_empty", 32'(sb_q.size()), 32'd0);

        // All three requesting: round-robin 0,1,2,0 with single-byte packets.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            sb_q.push_back(8'hA0 | 8'(order[k]));
            sb_q.push_back(8'h40 + 8'(k));
        end
        req = 3'b111;
        for (int k = 0; k < 4; k++) begin
            wait_grant(3'b001 << order[k]);
            send_byte(int'(order[k]), 8'h40 + 8'(k), 1'b1, 1'b0);
        end
        req = '0;
        cyc(); cyc(); cyc();
        chk("rr_sb_empty", 32'(sb_q.size()), 32'd0);
        chk("rr_no_err",   32'(err_seen), 32'd0);

        // UART busy for 20 cycles during SEND: nothing moves, no timeout.
        do_reset();
        sb_q.push_back(8'hA0); sb_q.push_back(8'h5A);
        req[0] = 1'b1;
        wait_starts(1);
        txBusy      = 1'b1;
        in_valid[0] = 1'b1;
        in_data[0]  = 8'h5A;
        in_last[0]  = 1'b1;
        for (int k = 0; k < 20; k++) begin
            cyc();
            chk("busy_no_rdy",   32'(rdy),        32'd0);
            chk("busy_no_start", 32'(start_w[0]), 32'd0);
        end
        txBusy = 1'b0;
        send_byte(0, 8'h5A, 1'b1, 1'b1);
        cyc(); cyc();
        chk("busy_no_err",   32'(err_seen),    32'd0);
        chk("busy_sb_empty", 32'(sb_q.size()), 32'd0);

        // Grantee drops req mid-packet: abort next cycle with an error pulse.
        do_reset();
        sb_q.push_back(8'hA1);
        req[1] = 1'b1;
        wait_starts(1);
        req[1] = 1'b0;
        cyc();
        chk("drop_err",   32'(err_w[0]),   32'd1);
        chk("drop_grant", 32'(grant_w[0]), 32'd0);
        chk("drop_busy",  32'(busy_w[0]),  32'd0);
        cyc();
        chk("drop_err_pulse", 32'(err_w[0]), 32'd0);

        // TIMEOUT=8 stall after header; abort, then grant moves to index 1.
        do_reset();
        sel = 1;
        sb_q.push_back(8'hA0); sb_q.push_back(8'hA1);
        req = 3'b011;
        wait_starts(1);
        for (int k = 1; k <= 11; k++) begin
            cyc();
            if (k < 9)   chk("to_early",   32'(err_w[1]), 32'd0);
            if (k == 9) begin
                chk("to_err",   32'(err_w[1]),   32'd1);
                chk("to_grant", 32'(grant_w[1]), 32'd0);
            end
            if (k == 10) begin
                chk("to_err_pulse", 32'(err_w[1]),   32'd0);
                chk("to_next",      32'(grant_w[1]), 32'b010);
            end
        end
        req = '0;
        cyc(); cyc();
        chk("to_sb_empty", 32'(sb_q.size()), 32'd0);

        // Reset while in GAP mid-packet; the packet restarts with its header.
        do_reset();
        sel = 0;
        sb_q.push_back(8'hA2); sb_q.push_back(8'h77);
        req[2] = 1'b1;
        wait_starts(1);
        send_byte(2, 8'h77, 1'b0, 1'b0);
        reset = 1'b1;
        cyc();
        chk("gaprst_grant", 32'(grant_w[0]), 32'd0);
        chk("gaprst_start", 32'(start_w[0]), 32'd0);
        chk("gaprst_busy",  32'(busy_w[0]),  32'd0);
        reset = 1'b0;
        sb_q.push_back(8'hA2); sb_q.push_back(8'h78);
        wait_grant(3'b100);
        send_byte(2, 8'h78, 1'b1, 1'b1);
        cyc(); cyc();
        chk("gaprst_sb_empty", 32'(sb_q.size()), 32'd0);

        // No header: req[2] arrives mid-packet and waits its turn.
        do_reset();
        sel = 2;
        sb_q.push_back(8'h01); sb_q.push_back(8'h02);
        sb_q.push_back(8'h03); sb_q.push_back(8'h09);
        req[0] = 1'b1;
        wait_grant(3'b001);
        send_byte(0, 8'h01, 1'b0, 1'b0);
        req[2] = 1'b1;
        send_byte(0, 8'h02, 1'b0, 1'b0);
        chk("atomic_grant", 32'(grant_w[2]), 32'b001);
        send_byte(0, 8'h03, 1'b1, 1'b1);
        wait_grant(3'b100);
        send_byte(2, 8'h09, 1'b1, 1'b1);
        cyc(); cyc();
        chk("nohdr_grant_clr", 32'(grant_w[2]), 32'd0);
        chk("nohdr_sb_empty",  32'(sb_q.size()), 32'd0);
        chk("nohdr_no_err",    32'(err_seen),    32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
